// File: rtl/pool_input_buffer.sv
// Pairs consecutive conv rows of one feature map and emits 2x2 max-pooled rows.
// Optional macro POOL_RELU_EN: zero pooled pixels whose sign bit is set.
module pool_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_PIXELS = 6,
  parameter int MAP_ROWS   = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               kernel_calc_fin,
  input  logic [1:0]                         feature_idx,
  input  logic [DATA_WIDTH*ROW_PIXELS-1:0]   feature_output,
  output logic                               pool_valid,
  output logic [DATA_WIDTH*ROW_PIXELS/2-1:0] pool_out,
  output logic [1:0]                         pool_row,
  output logic [1:0]                         pool_idx,
  output logic                               map_done,
  output logic                               seq_err
);
  localparam int W   = DATA_WIDTH;
  localparam int OP  = ROW_PIXELS / 2;
  localparam int IW  = W * ROW_PIXELS;
  localparam int OW  = W * OP;
  localparam logic [1:0] LAST_ROW = 2'(MAP_ROWS / 2 - 1);

  typedef enum logic {S_EVEN, S_ODD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   hold_q, hold_d;
  logic [1:0]      hold_idx_q, hold_idx_d;
  logic [1:0]      last_idx_q, last_idx_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pool_valid_q, pool_valid_d;
  logic [OW-1:0]   pool_out_q, pool_out_d;
  logic [1:0]      pool_row_q, pool_row_d;
  logic [1:0]      pool_idx_q, pool_idx_d;
  logic            map_done_q, map_done_d;
  logic            seq_err_q, seq_err_d;
  logic [OW-1:0]   pooled;

  // a > b on raw float bits; +0 and -0 compare equal
  function automatic logic f_gt(input logic [W-1:0] a,
                                input logic [W-1:0] b);
    logic sa, sb;
    logic [W-2:0] ma, mb;
    sa = a[W-1];
    sb = b[W-1];
    ma = a[W-2:0];
    mb = b[W-2:0];
    if (sa != sb) f_gt = !sa && ((ma | mb) != '0);
    else if (!sa) f_gt = ma > mb;
    else          f_gt = ma < mb;
  endfunction

  always_comb begin
    logic [W-1:0] a0, a1, b0, b1, m0, m1, mx;
    pooled = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    m0 = '0; m1 = '0; mx = '0;
    for (int j = 0; j < OP; j++) begin
      a0 = hold_q[(ROW_PIXELS-1-2*j)*W +: W];
      a1 = hold_q[(ROW_PIXELS-2-2*j)*W +: W];
      b0 = feature_output[(ROW_PIXELS-1-2*j)*W +: W];
      b1 = feature_output[(ROW_PIXELS-2-2*j)*W +: W];
      m0 = f_gt(a1, a0) ? a1 : a0;
      m1 = f_gt(b1, b0) ? b1 : b0;
      mx = f_gt(m1, m0) ? m1 : m0;
`ifdef POOL_RELU_EN
      if (mx[W-1]) mx = '0;
`endif
      pooled[(OP-1-j)*W +: W] = mx;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_idx_d   = hold_idx_q;
    last_idx_d   = last_idx_q;
    cnt_d        = cnt_q;
    pool_valid_d = 1'b0;
    pool_out_d   = pool_out_q;
    pool_row_d   = pool_row_q;
    pool_idx_d   = pool_idx_q;
    map_done_d   = 1'b0;
    seq_err_d    = seq_err_q;
    if (kernel_calc_fin) begin
      unique case (state_q)
        S_EVEN: begin
          hold_d     = feature_output;
          hold_idx_d = feature_idx;
          state_d    = S_ODD;
          if (feature_idx != last_idx_q && cnt_q != 2'd0) begin
            cnt_d     = 2'd0;
            seq_err_d = 1'b1;
          end
        end
        S_ODD: begin
          if (feature_idx == hold_idx_q) begin
            pool_valid_d = 1'b1;
            pool_out_d   = pooled;
            pool_row_d   = cnt_q;
            pool_idx_d   = hold_idx_q;
            map_done_d   = (cnt_q == LAST_ROW);
            cnt_d        = (cnt_q == LAST_ROW) ? 2'd0 : cnt_q + 2'd1;
            last_idx_d   = hold_idx_q;
            state_d      = S_EVEN;
          end else begin
            // map switched mid-pair: held row is orphaned
            hold_d     = feature_output;
            hold_idx_d = feature_idx;
            cnt_d      = 2'd0;
            seq_err_d  = 1'b1;
          end
        end
        default: state_d = S_EVEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_EVEN;
      hold_q       <= '0;
      hold_idx_q   <= '0;
      last_idx_q   <= '0;
      cnt_q        <= '0;
      pool_valid_q <= 1'b0;
      pool_out_q   <= '0;
      pool_row_q   <= '0;
      pool_idx_q   <= '0;
      map_done_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_idx_q   <= hold_idx_d;
      last_idx_q   <= last_idx_d;
      cnt_q        <= cnt_d;
      pool_valid_q <= pool_valid_d;
      pool_out_q   <= pool_out_d;
      pool_row_q   <= pool_row_d;
      pool_idx_q   <= pool_idx_d;
      map_done_q   <= map_done_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign pool_valid = pool_valid_q;
  assign pool_out   = pool_out_q;
  assign pool_row   = pool_row_q;
  assign pool_idx   = pool_idx_q;
  assign map_done   = map_done_q;
  assign seq_err    = seq_err_q;
endmodule
